decode_stage: RTL and testbench

Instruction decode stage of the 32-bit RISC-V pipeline: the consumer of the fetch stage's PC/instruction outputs and the producer of its `d_ready`, `br_en` and `br_addr` controls. It registers one fetched instruction and extracts its register fields and sign-extended immediate. It presents the decoded instruction to execute with a valid/ready handshake, stalls fetch on back-pressure and load-use hazards, and arbitrates fetch redirects between execute and its own JAL resolution.

---
 rtl/decode_stage.sv | 189 ++++++++++++++++++
 tb/tb_decode_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Instruction decode stage of the 32-bit RISC-V pipeline. It registers one
// fetched instruction (the D register), extracts its fields and the
// sign-extended immediate, and offers the result to execute with a
// valid/ready handshake. It stalls fetch on execute back-pressure and on
// load-use hazards, and arbitrates fetch redirects between execute and its
// own JAL resolution.
//
// Build option:
//   DECODE_JAL_EN - when defined, a JAL sitting in D redirects fetch from
//                   here (br_addr = d_pc + J-imm). When undefined, br_en and
//                   br_addr simply forward execute's redirect.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   f_pc_i, f_instr_i       PC / instruction word offered by fetch
//   d_ready                 fetch may advance; D captures fetch this edge
//   br_en, br_addr          fetch redirect request and target
//   x_ready                 execute accepts the decoded instruction
//   x_br_en, x_br_addr      execute redirect (highest priority)
//   x_ld_valid, x_ld_rd     load in execute and its destination register
//   d_valid_o               decoded instruction offered to execute
//   d_pc_o                  PC of the decoded instruction
//   d_opcode_o, d_funct3_o, d_funct7_o, d_rd_o, d_rs1_o, d_rs2_o
//                           instruction fields
//   d_imm_o                 sign-extended immediate (0 for R-type)
//   d_illegal_o             opcode outside the supported set
// ---------------------------------------------------------------------------
module decode_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] f_pc_i,
  input  logic [31:0] f_instr_i,
  output logic        d_ready,
  output logic        br_en,
  output logic [31:0] br_addr,
  input  logic        x_ready,
  input  logic        x_br_en,
  input  logic [31:0] x_br_addr,
  input  logic        x_ld_valid,
  input  logic [4:0]  x_ld_rd,
  output logic        d_valid_o,
  output logic [31:0] d_pc_o,
  output logic [6:0]  d_opcode_o,
  output logic [2:0]  d_funct3_o,
  output logic [6:0]  d_funct7_o,
  output logic [4:0]  d_rd_o,
  output logic [4:0]  d_rs1_o,
  output logic [4:0]  d_rs2_o,
  output logic [31:0] d_imm_o,
  output logic        d_illegal_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int NUM_OPS = 9;
  localparam logic [NUM_OPS-1:0][6:0] LEGAL_OPS = {
    OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH,
    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
  };

  // D register
  logic        d_vld_reg;
  logic [31:0] d_pc_reg;
  logic [31:0] d_instr_reg;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] imm_sel;
  logic [NUM_OPS-1:0] op_hit;
  logic        op_legal;
  logic        uses_rs1, uses_rs2;
  logic        hz, stall;

  assign opcode = d_instr_reg[6:0];
  assign rd     = d_instr_reg[11:7];
  assign rs1    = d_instr_reg[19:15];
  assign rs2    = d_instr_reg[24:20];

  // Opcode legality: one comparator per supported opcode.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_legal
      assign op_hit[gi] = (opcode == LEGAL_OPS[gi]);
    end
  endgenerate
  assign op_legal = |op_hit;

  // Immediate formats, all sign-extended from instr[31].
  assign imm_i = {{20{d_instr_reg[31]}}, d_instr_reg[31:20]};
  assign imm_s = {{20{d_instr_reg[31]}}, d_instr_reg[31:25], d_instr_reg[11:7]};
  assign imm_b = {{19{d_instr_reg[31]}}, d_instr_reg[31], d_instr_reg[7],
                  d_instr_reg[30:25], d_instr_reg[11:8], 1'b0};
  assign imm_u = {d_instr_reg[31:12], 12'b0};
  assign imm_j = {{11{d_instr_reg[31]}}, d_instr_reg[31], d_instr_reg[19:12],
                  d_instr_reg[20], d_instr_reg[30:21], 1'b0};

  always_comb begin
    imm_sel  = 32'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R:      begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_IALU:   begin imm_sel = imm_i; uses_rs1 = 1'b1; end
      OP_LOAD:   begin imm_sel = imm_i; uses_rs1 = 1'b1; end
      OP_JALR:   begin imm_sel = imm_i; uses_rs1 = 1'b1; end
      OP_STORE:  begin imm_sel = imm_s; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_BRANCH: begin imm_sel = imm_b; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_LUI:    imm_sel = imm_u;
      OP_AUIPC:  imm_sel = imm_u;
      OP_JAL:    imm_sel = imm_j;
      default:   imm_sel = 32'b0;
    endcase
  end

  // Load-use hazard: the load result is not yet available to D's sources.
  assign hz = d_vld_reg & x_ld_valid & (x_ld_rd != 5'd0) &
              ((uses_rs1 & (rs1 == x_ld_rd)) | (uses_rs2 & (rs2 == x_ld_rd)));

  // An execute redirect kills D, so it never needs to hold.
  assign stall   = d_vld_reg & (hz | ~x_ready) & ~x_br_en;
  assign d_ready = ~stall;

  // Redirect arbitration: execute first, then (optionally) JAL in D.
`ifdef DECODE_JAL_EN
  logic jal_redirect;
  assign jal_redirect = d_vld_reg & (opcode == OP_JAL) & ~stall;

  always_comb begin
    br_en   = 1'b0;
    br_addr = 32'b0;
    if (x_br_en) begin
      br_en   = 1'b1;
      br_addr = x_br_addr;
    end else if (jal_redirect) begin
      br_en   = 1'b1;
      br_addr = d_pc_reg + imm_j;
    end
  end
`else
  always_comb begin
    br_en   = x_br_en;
    br_addr = x_br_en ? x_br_addr : 32'b0;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      d_vld_reg   <= 1'b0;
      d_pc_reg    <= 32'b0;
      d_instr_reg <= NOP_INSTR;
    end else if (x_br_en) begin
      d_vld_reg <= 1'b0;
    end else if (stall) begin
      d_vld_reg <= d_vld_reg;
    end else if (br_en) begin
      // JAL in D completes its handshake; the wrong-path fetch is dropped.
      d_vld_reg <= 1'b0;
    end else begin
      d_vld_reg   <= 1'b1;
      d_pc_reg    <= f_pc_i;
      d_instr_reg <= f_instr_i;
    end
  end

  assign d_valid_o   = d_vld_reg & ~hz;
  assign d_pc_o      = d_pc_reg;
  assign d_opcode_o  = opcode;
  assign d_funct3_o  = d_instr_reg[14:12];
  assign d_funct7_o  = d_instr_reg[31:25];
  assign d_rd_o      = rd;
  assign d_rs1_o     = rs1;
  assign d_rs2_o     = rs2;
  assign d_imm_o     = imm_sel;
  assign d_illegal_o = d_vld_reg & ~op_legal;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Directed stimulus for decode_stage. Each stimulus cycle drives inputs just
// after the rising edge and pushes the outputs it expects during that cycle
// into a queue; a monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_decode_stage;

  logic        clock;
  logic        reset;
  logic [31:0] f_pc_i, f_instr_i;
  logic        d_ready, br_en;
  logic [31:0] br_addr;
  logic        x_ready, x_br_en;
  logic [31:0] x_br_addr;
  logic        x_ld_valid;
  logic [4:0]  x_ld_rd;
  logic        d_valid_o;
  logic [31:0] d_pc_o;
  logic [6:0]  d_opcode_o;
  logic [2:0]  d_funct3_o;
  logic [6:0]  d_funct7_o;
  logic [4:0]  d_rd_o, d_rs1_o, d_rs2_o;
  logic [31:0] d_imm_o;
  logic        d_illegal_o;

  decode_stage dut (
    .clock(clock), .reset(reset),
    .f_pc_i(f_pc_i), .f_instr_i(f_instr_i),
    .d_ready(d_ready), .br_en(br_en), .br_addr(br_addr),
    .x_ready(x_ready), .x_br_en(x_br_en), .x_br_addr(x_br_addr),
    .x_ld_valid(x_ld_valid), .x_ld_rd(x_ld_rd),
    .d_valid_o(d_valid_o), .d_pc_o(d_pc_o), .d_opcode_o(d_opcode_o),
    .d_funct3_o(d_funct3_o), .d_funct7_o(d_funct7_o),
    .d_rd_o(d_rd_o), .d_rs1_o(d_rs1_o), .d_rs2_o(d_rs2_o),
    .d_imm_o(d_imm_o), .d_illegal_o(d_illegal_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    bit          dec;      // also compare decoded fields
    logic        valid;
    logic        ready;
    logic        br_en;
    logic [31:0] br_addr;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADDI1 = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] ADDI2 = 32'h0070_0113; // addi x2,x0,7
  localparam logic [31:0] JAL16 = 32'h0100_006F; // jal x0,+16
  localparam logic [31:0] ADD   = 32'h0062_81B3; // add x3,x5,x6
  localparam logic [31:0] SWN4  = 32'hFE20_AE23; // sw x2,-4(x1)
  localparam logic [31:0] ILL   = 32'h0000_007F;
  localparam logic [31:0] BEQN8 = 32'hFE20_8CE3; // beq x1,x2,-8
  localparam logic [31:0] LUI7  = 32'h1234_53B7; // lui x7,0x12345

  task automatic drv(input logic rst, input logic [31:0] fpc, input logic [31:0] fin,
                     input logic xr, input logic xb, input logic [31:0] xba,
                     input logic lv, input logic [4:0] lrd);
    @(posedge clock);
    #1;
    reset      = rst;
    f_pc_i     = fpc;
    f_instr_i  = fin;
    x_ready    = xr;
    x_br_en    = xb;
    x_br_addr  = xba;
    x_ld_valid = lv;
    x_ld_rd    = lrd;
  endtask

  task automatic ex(input string name, input bit dec, input logic v, input logic r,
                    input logic be, input logic [31:0] ba, input logic [31:0] pc,
                    input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                    input logic [4:0] rs2, input logic [31:0] imm, input logic ill);
    exp_t e;
    e.name = name; e.dec = dec; e.valid = v; e.ready = r; e.br_en = be;
    e.br_addr = ba; e.pc = pc; e.opcode = op; e.rd = rd; e.rs1 = rs1;
    e.rs2 = rs2; e.imm = imm; e.illegal = ill;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
    end
  endtask

  // Monitor: compares every pending expectation in the middle of the cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "d_valid_o", {31'b0, d_valid_o}, {31'b0, e.valid});
        chk(e.name, "d_ready",   {31'b0, d_ready},   {31'b0, e.ready});
        chk(e.name, "br_en",     {31'b0, br_en},     {31'b0, e.br_en});
        chk(e.name, "br_addr",   br_addr,            e.br_addr);
        chk(e.name, "d_illegal", {31'b0, d_illegal_o}, {31'b0, e.illegal});
        if (e.dec) begin
          chk(e.name, "d_pc",     d_pc_o,               e.pc);
          chk(e.name, "d_opcode", {25'b0, d_opcode_o},  {25'b0, e.opcode});
          chk(e.name, "d_rd",     {27'b0, d_rd_o},      {27'b0, e.rd});
          chk(e.name, "d_rs1",    {27'b0, d_rs1_o},     {27'b0, e.rs1});
          chk(e.name, "d_rs2",    {27'b0, d_rs2_o},     {27'b0, e.rs2});
          chk(e.name, "d_imm",    d_imm_o,              e.imm);
        end
        $display("txn %s valid=%0d ready=%0d br_en=%0d br_addr=%h pc=%h imm=%h",
                 e.name, d_valid_o, d_ready, br_en, br_addr, d_pc_o, d_imm_o);
      end
    end
  end

  initial begin
    reset = 1'b1; f_pc_i = 32'b0; f_instr_i = NOP; x_ready = 1'b1;
    x_br_en = 1'b0; x_br_addr = 32'b0; x_ld_valid = 1'b0; x_ld_rd = 5'd0;

    // Reset state: NOP fields, nothing offered, fetch free.
    drv(1, 32'h0, NOP, 1, 0, 32'h0, 0, 0);
    ex("reset", 1, 0, 1, 0, 32'h0, 32'h0, 7'h13, 0, 0, 0, 32'h0, 0);

    // Fetch offers addi x1,x0,5 at PC 0.
    drv(0, 32'h0, ADDI1, 1, 0, 32'h0, 0, 0);
    ex("empty", 0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);

    // addi in D; fetch offers JAL at 0x10.
    drv(0, 32'h10, JAL16, 1, 0, 32'h0, 0, 0);
    ex("addi", 1, 1, 1, 0, 32'h0, 32'h0, 7'h13, 1, 0, 5, 32'h5, 0);

    // JAL in D; fetch offers the wrong-path addi at 0x14.
    drv(0, 32'h14, ADDI2, 1, 0, 32'h0, 0, 0);
`ifdef DECODE_JAL_EN
    ex("jal", 1, 1, 1, 1, 32'h20, 32'h10, 7'h6F, 0, 0, 16, 32'h10, 0);
    // Bubble after the redirect; fetch now at the target.
    drv(0, 32'h20, ADD, 1, 0, 32'h0, 0, 0);
    ex("jal_bubble", 0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
`else
    ex("jal", 1, 1, 1, 0, 32'h0, 32'h10, 7'h6F, 0, 0, 16, 32'h10, 0);
    // Execute redirects for the JAL while D holds the wrong-path addi.
    drv(0, 32'h18, NOP, 1, 1, 32'h20, 0, 0);
    ex("x_jal", 1, 1, 1, 1, 32'h20, 32'h14, 7'h13, 2, 0, 7, 32'h7, 0);
    drv(0, 32'h20, ADD, 1, 0, 32'h0, 0, 0);
    ex("x_jal_bubble", 0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
`endif

    // add x3,x5,x6 in D while a load to x5 is in execute.
    drv(0, 32'h24, SWN4, 1, 0, 32'h0, 1, 5);
    ex("load_use", 1, 0, 0, 0, 32'h0, 32'h20, 7'h33, 3, 5, 6, 32'h0, 0);
    drv(0, 32'h24, SWN4, 1, 0, 32'h0, 0, 0);
    ex("load_use_rel", 1, 1, 1, 0, 32'h0, 32'h20, 7'h33, 3, 5, 6, 32'h0, 0);

    // sw x2,-4(x1) in D; execute back-pressures for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      drv(0, 32'h28 + 32'(i * 4), ILL, 0, 0, 32'h0, 0, 0);
      ex($sformatf("xbusy%0d", i), 1, 1, 0, 0, 32'h0, 32'h24, 7'h23, 5'h1C, 1, 2,
         32'hFFFF_FFFC, 0);
    end
    drv(0, 32'h28, ILL, 1, 0, 32'h0, 0, 0);
    ex("xbusy_rel", 1, 1, 1, 0, 32'h0, 32'h24, 7'h23, 5'h1C, 1, 2, 32'hFFFF_FFFC, 0);

    // Illegal opcode: still offered, no redirect.
    drv(0, 32'h2C, JAL16, 1, 0, 32'h0, 0, 0);
    ex("illegal", 1, 1, 1, 0, 32'h0, 32'h28, 7'h7F, 0, 0, 0, 32'h0, 1);

    // JAL in D, execute busy but redirecting: execute wins.
    drv(0, 32'h30, NOP, 0, 1, 32'h100, 0, 0);
    ex("x_br_prio", 1, 1, 1, 1, 32'h100, 32'h2C, 7'h6F, 0, 0, 16, 32'h10, 0);
    drv(0, 32'h100, BEQN8, 1, 0, 32'h0, 0, 0);
    ex("x_br_bubble", 0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);

    // beq x1,x2,-8 with a load to x2 (rs2 hazard), then released.
    drv(0, 32'h104, LUI7, 1, 0, 32'h0, 1, 2);
    ex("beq_hz", 1, 0, 0, 0, 32'h0, 32'h100, 7'h63, 5'h19, 1, 2, 32'hFFFF_FFF8, 0);
    drv(0, 32'h104, LUI7, 1, 0, 32'h0, 0, 0);
    ex("beq", 1, 1, 1, 0, 32'h0, 32'h100, 7'h63, 5'h19, 1, 2, 32'hFFFF_FFF8, 0);

    // lui x7: load to x0 never creates a hazard.
    drv(0, 32'h108, ADD, 1, 0, 32'h0, 1, 0);
    ex("lui", 1, 1, 1, 0, 32'h0, 32'h104, 7'h37, 7, 5'h08, 5'h03, 32'h1234_5000, 0);

    // add in D stalled, then reset asserted mid-stall.
    drv(0, 32'h10C, NOP, 0, 0, 32'h0, 0, 0);
    ex("stall", 1, 1, 0, 0, 32'h0, 32'h108, 7'h33, 3, 5, 6, 32'h0, 0);
    drv(1, 32'h10C, NOP, 0, 0, 32'h0, 0, 0);
    drv(0, 32'h10C, NOP, 0, 0, 32'h0, 0, 0);
    ex("reset_stall", 1, 0, 1, 0, 32'h0, 32'h0, 7'h13, 0, 0, 0, 32'h0, 0);

    @(posedge clock);
    @(negedge clock);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
